ps2_event_rx: RTL and testbench

Parametrised PS/2 keyboard receiver that turns raw `ps2clk`/`ps2data` into typed key events. It handles both make and break codes, the E0 extended prefix and the F0 release prefix. Decoded events are buffered in a first-word-fall-through FIFO with a valid/ready handshake. It sits between the PS/2 pins and any command decoder, such as the shape/size controller, which then no longer deals with framing, glitches or lost bytes.

---
 rtl/ps2_event_rx_if.sv | 25 ++
 rtl/ps2_event_rx.sv | 239 +++++++++++++++++++++++
 tb/tb_ps2_event_rx.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_event_rx_if.sv
// Event stream from the PS/2 receiver to its consumer: head-of-FIFO
// event plus a valid/ready handshake.
interface ps2_event_rx_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_release;
  logic       ev_extended;

  modport master (
    output ev_valid,
    output ev_code,
    output ev_release,
    output ev_extended,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_code,
    input  ev_release,
    input  ev_extended,
    output ev_ready
  );
endinterface

// File: rtl/ps2_event_rx.sv
// PS/2 keyboard receiver: pin synchronisers, ps2clk glitch filter, frame
// FSM with timeout, E0/F0 prefix decoding and a first-word-fall-through
// event FIFO.
module ps2_event_rx #(
  parameter  int FILTER_LEN     = 8,
  parameter  int TIMEOUT_CYCLES = 50000,
  parameter  int FIFO_DEPTH     = 8,
  localparam int AW             = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2clk,
  input  logic          ps2data,
  input  logic          clr_overflow,
  ps2_event_rx_if.master ev,
  output logic [AW:0]   fifo_count,
  output logic          parity_err,
  output logic          frame_err,
  output logic          overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Odd parity: data bits plus parity bit must XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic [1:0]            clk_sync_r, data_sync_r;
  logic [FILTER_LEN-1:0] samp_r;
  logic                  filt_r;
  logic                  ps2clk_s, ps2data_s, fe_s, timeout_s;

  state_t     state_r, state_n;
  logic [2:0] bit_cnt_r, bit_cnt_n;
  logic [7:0] shift_r, shift_n;
  logic       par_r, par_n;
  logic [TW-1:0] to_cnt_r;
  logic       perr_n, ferr_n, byte_v_n;
  logic       byte_valid_r;
  logic [7:0] byte_r;

  logic       ext_pend_r, rel_pend_r, push_s;

  logic [9:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r, count_n;
  logic          ev_valid_r, full_s, pop_s, do_push_s, drop_s;

  assign ps2clk_s  = clk_sync_r[1];
  assign ps2data_s = data_sync_r[1];
  assign fe_s      = filt_r & ~(|samp_r);
  assign timeout_s = (state_r != S_IDLE) && !fe_s &&
                     (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Two-flop synchronisers, preset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2clk};
      data_sync_r <= {data_sync_r[0], ps2data};
    end
  end

  // Clock filter: level changes only after FILTER_LEN agreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_r <= {FILTER_LEN{1'b1}};
      filt_r <= 1'b1;
    end else begin
      samp_r <= {samp_r[FILTER_LEN-2:0], ps2clk_s};
      if (&samp_r) begin
        filt_r <= 1'b1;
      end else if (~(|samp_r)) begin
        filt_r <= 1'b0;
      end
    end
  end

  // Frame FSM next state; a timeout overrides any edge activity.
  always_comb begin
    state_n   = state_r;
    bit_cnt_n = bit_cnt_r;
    shift_n   = shift_r;
    par_n     = par_r;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    byte_v_n  = 1'b0;
    if (timeout_s) begin
      state_n = S_IDLE;
      ferr_n  = 1'b1;
    end else if (fe_s) begin
      case (state_r)
        S_IDLE: begin
          if (!ps2data_s) begin
            state_n   = S_DATA;
            bit_cnt_n = 3'd0;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_DATA: begin
          shift_n   = {ps2data_s, shift_r[7:1]};
          bit_cnt_n = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_n = S_PARITY;
          end else begin
            state_n = S_DATA;
          end
        end
        S_PARITY: begin
          par_n   = ps2data_s;
          state_n = S_STOP;
        end
        S_STOP: begin
          state_n = S_IDLE;
          if (!odd_parity_ok(shift_r, par_r)) begin
            perr_n = 1'b1;
          end else if (!ps2data_s) begin
            ferr_n = 1'b1;
          end else begin
            byte_v_n = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Frame FSM registers, timeout counter and registered error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'd0;
      par_r        <= 1'b0;
      to_cnt_r     <= {TW{1'b0}};
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      byte_valid_r <= 1'b0;
      byte_r       <= 8'd0;
    end else begin
      state_r      <= state_n;
      bit_cnt_r    <= bit_cnt_n;
      shift_r      <= shift_n;
      par_r        <= par_n;
      parity_err   <= perr_n;
      frame_err    <= ferr_n;
      byte_valid_r <= byte_v_n;
      byte_r       <= shift_r;
      if (fe_s || (state_r == S_IDLE)) begin
        to_cnt_r <= {TW{1'b0}};
      end else begin
        to_cnt_r <= to_cnt_r + TW'(1);
      end
    end
  end

  assign push_s = byte_valid_r && (byte_r != 8'hE0) && (byte_r != 8'hF0);

  // Prefix flags: E0/F0 arm them, any other byte or an error clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_pend_r <= 1'b0;
      rel_pend_r <= 1'b0;
    end else if (parity_err || frame_err) begin
      ext_pend_r <= 1'b0;
      rel_pend_r <= 1'b0;
    end else if (byte_valid_r) begin
      case (byte_r)
        8'hE0:   ext_pend_r <= 1'b1;
        8'hF0:   rel_pend_r <= 1'b1;
        default: begin
          ext_pend_r <= 1'b0;
          rel_pend_r <= 1'b0;
        end
      endcase
    end
  end

  assign full_s    = (count_r == (AW+1)'(FIFO_DEPTH));
  assign pop_s     = ev_valid_r && ev.ev_ready;
  assign do_push_s = push_s && (!full_s || pop_s);
  assign drop_s    = push_s && full_s && !pop_s;

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_n = count_r;
    case ({do_push_s, pop_s})
      2'b10:   count_n = count_r + {{AW{1'b0}}, 1'b1};
      2'b01:   count_n = count_r - {{AW{1'b0}}, 1'b1};
      default: count_n = count_r;
    endcase
  end

  // FIFO storage, pointers, count and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      ev_valid_r <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= {ext_pend_r, rel_pend_r, byte_r};
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r    <= count_n;
      ev_valid_r <= (count_n != {(AW+1){1'b0}});
      if (drop_s) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  assign fifo_count     = count_r;
  assign ev.ev_valid    = ev_valid_r;
  assign ev.ev_code     = ev_valid_r ? mem_r[rd_ptr_r][7:0] : 8'd0;
  assign ev.ev_release  = ev_valid_r ? mem_r[rd_ptr_r][8]   : 1'b0;
  assign ev.ev_extended = ev_valid_r ? mem_r[rd_ptr_r][9]   : 1'b0;

endmodule

// File: tb/tb_ps2_event_rx.sv
// Scoreboard bench for ps2_event_rx: PS/2 frames are bit-banged onto the
// pins, a byte-level reference model predicts events and error pulses,
// and independent monitors compare whatever the DUT presents.
module tb_ps2_event_rx;
  localparam int FL    = 4;
  localparam int TO    = 1000;
  localparam int DEPTH = 4;
  localparam int HALF  = 100;

  logic       clk = 1'b0;
  logic       reset, ps2clk, ps2data, clr_overflow;
  logic [2:0] fifo_count;
  logic       parity_err, frame_err, overflow;

  ps2_event_rx_if ev_if ();

  ps2_event_rx #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2clk      (ps2clk),
    .ps2data     (ps2data),
    .clr_overflow(clr_overflow),
    .ev          (ev_if),
    .fifo_count  (fifo_count),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors    = 0;
  int miscompares = 0;

  // Expected events {ext, rel, code} and error kinds (1 parity, 2 frame).
  logic [9:0] exp_q[$];
  int         err_q[$];
  bit         m_ext = 1'b0, m_rel = 1'b0, exp_ovf = 1'b0;

  int last_fall      = 0;
  int valid_rise_cyc = -1;
  int ferr_cyc       = -1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Byte-level reference: what a received byte means for events/errors.
  task automatic model_byte(input logic [7:0] b, input bit badp, input bit bads,
                            input bit pop_at_push);
    if (badp) begin
      err_q.push_back(1);
      m_ext = 1'b0; m_rel = 1'b0;
    end else if (bads) begin
      err_q.push_back(2);
      m_ext = 1'b0; m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      if (exp_q.size() >= DEPTH && !ev_if.ev_ready && !pop_at_push) exp_ovf = 1'b1;
      else exp_q.push_back({m_ext, m_rel, b});
      m_ext = 1'b0; m_rel = 1'b0;
    end
  endtask

  // Device-side frame: data changes while clock is high, host samples on fall.
  task automatic send_frame(input logic [7:0] b, input bit badp, input bit bads,
                            input bit glitch, input bit pop_at_push, input int nbits);
    logic [10:0] bits;
    int glen;
    bits = {~bads, (~^b) ^ badp, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2data = bits[i];
      glen = $urandom_range(3, 1);
      for (int c = 1; c <= HALF; c++) begin
        @(posedge clk); #1;
        if (glitch && c == 40) ps2clk = 1'b0;
        if (glitch && c == 40 + glen) ps2clk = 1'b1;
      end
      ps2clk = 1'b0;
      last_fall = cyc;
      if (i == 10) model_byte(b, badp, bads, pop_at_push);
      for (int c = 1; c <= HALF; c++) begin
        @(posedge clk); #1;
        if (pop_at_push && i == 10 && c == 7) ev_if.ev_ready = 1'b1;
        if (pop_at_push && i == 10 && c == 8) ev_if.ev_ready = 1'b0;
      end
      ps2clk = 1'b1;
    end
    ps2data = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0, 11);
  endtask

  // Event monitor: every accepted head event is popped and compared.
  bit valid_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (ev_if.ev_valid && !valid_prev) valid_rise_cyc = cyc;
      if (ev_if.ev_valid && ev_if.ev_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {ev_if.ev_extended, ev_if.ev_release, ev_if.ev_code}, 1024);
        end else begin
          check("event", {ev_if.ev_extended, ev_if.ev_release, ev_if.ev_code}, exp_q.pop_front());
        end
      end
    end
    valid_prev = ev_if.ev_valid;
  end

  // Error monitor: pulse kind against expectation, pulse width of one cycle.
  int perr_len = 0, ferr_len = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (parity_err && perr_len == 0)
        check("err_kind_parity", 1, (err_q.size() != 0) ? err_q.pop_front() : 0);
      if (frame_err && ferr_len == 0) begin
        ferr_cyc = cyc;
        check("err_kind_frame", 2, (err_q.size() != 0) ? err_q.pop_front() : 0);
      end
      if (!parity_err && perr_len != 0) check("parity_err_width", perr_len, 1);
      if (!frame_err && ferr_len != 0) check("frame_err_width", ferr_len, 1);
    end
    perr_len = parity_err ? perr_len + 1 : 0;
    ferr_len = frame_err ? ferr_len + 1 : 0;
  end

  task automatic check_all_zero(input string name);
    @(negedge clk);
    check({name, "_outputs"},
          {ev_if.ev_valid, ev_if.ev_code, ev_if.ev_release, ev_if.ev_extended,
           parity_err, frame_err, overflow}, 0);
    check({name, "_count"}, fifo_count, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] code;
    int pick;
    bit badp, bads;
    reset = 1'b1; ps2clk = 1'b1; ps2data = 1'b1; clr_overflow = 1'b0;
    ev_if.ev_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    check_all_zero("reset");
    repeat (20) @(posedge clk);
    #1;

    // Plain make code and its output latency.
    valid_rise_cyc = -1;
    send(8'h1C);
    check("ev_latency", valid_rise_cyc - last_fall, 2 + FL + 2);

    // Extended release, then plain make.
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h75);

    // Parity error, stop-bit error, error clearing a pending F0.
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 11);
    send(8'hF0);
    send_frame(8'h2D, 1'b1, 1'b0, 1'b0, 1'b0, 11);
    send(8'h2D);

    // Abandoned frame: start plus 3 data bits, then idle.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    err_q.push_back(2);
    ferr_cyc = -1;
    begin
      int fall0;
      fall0 = last_fall;
      repeat (TO + 100) @(posedge clk);
      #1;
      check_range("timeout_latency", ferr_cyc - fall0, TO + FL + 2, TO + FL + 4);
    end
    send(8'h2B);

    // Overflow with consumer stalled, drain, clear.
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
    check("full_count", fifo_count, DEPTH);
    check("overflow_set", overflow, exp_ovf);
    ev_if.ev_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("drained_count", fifo_count, 0);
    clr_overflow = 1'b1;
    @(posedge clk); #1;
    clr_overflow = 1'b0;
    exp_ovf = 1'b0;
    check("overflow_clr", overflow, exp_ovf);

    // Push and pop in the same cycle while full.
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
    check("refill_count", fifo_count, DEPTH);
    send_frame(8'h24, 1'b0, 1'b0, 1'b0, 1'b1, 11);
    check("pushpop_count", fifo_count, DEPTH);
    check("pushpop_overflow", overflow, 0);
    ev_if.ev_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("redrained_count", fifo_count, 0);

    // Randomised frames with clock glitches, prefixes and errors.
    for (int n = 0; n < 10; n++) begin
      pick = $urandom_range(9, 0);
      code = (pick < 2) ? 8'hE0 : (pick < 4) ? 8'hF0 : 8'($urandom_range(255, 0));
      badp = ($urandom_range(9, 0) == 0);
      bads = !badp && ($urandom_range(9, 0) == 0);
      send_frame(code, badp, bads, $urandom_range(1, 0) == 1, 1'b0, 11);
    end

    // Reset mid-frame with an E0 pending, then a clean frame.
    send(8'hE0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_ext = 1'b0; m_rel = 1'b0;
    check_all_zero("midframe_reset");
    valid_rise_cyc = -1;
    send(8'h1C);
    check("post_reset_latency", valid_rise_cyc - last_fall, 2 + FL + 2);

    repeat (50) @(posedge clk);
    #1;
    check("events_outstanding", exp_q.size(), 0);
    check("errors_outstanding", err_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
